neuron_mac_act: RTL

//  Parametrised fixed-point neuron. Computes act_out = f(sum_k w[k]*x[k] + bias) over N_IN
//  (data, weight) pairs streamed one pair per beat via a valid/ready handshake.

---
 rtl/neuron_mac_act.sv | 124 ++++++++++++
 1 files changed

// File: rtl/neuron_mac_act.sv
// neuron_mac_act: streamed fixed-point MAC neuron with bias, rescale, saturation.
// Define NEURON_RELU_EN to rectify the saturated result (ReLU); default build is linear.
module neuron_mac_act #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 15,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] weight_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] act_out,
  output logic              ovf,
  output logic              busy
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_BIAS, S_ACT, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic [DATA_W-1:0]        bias_r;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  r;
  logic [DATA_W-1:0]        sat_val;
  logic [DATA_W-1:0]        act_val;
  logic                     sat_ovf;
  logic                     beat;
  logic                     last_beat;

  assign beat      = in_valid && in_ready;
  assign last_beat = (count == CNT_W'(N_IN - 1));

  assign prod = $signed({{DATA_W{data_in[DATA_W-1]}}, data_in}) *
                $signed({{DATA_W{weight_in[DATA_W-1]}}, weight_in});
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Bias is shifted up so its Q format lines up with the product sum
  assign bias_ext = {{(ACC_W-DATA_W){bias_r[DATA_W-1]}}, bias_r} <<< FRAC_W;

  always_comb begin
    r       = acc >>> FRAC_W;
    sat_val = r[DATA_W-1:0];
    sat_ovf = 1'b0;
    if (r > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
      sat_ovf = 1'b1;
    end else if (r < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
      sat_ovf = 1'b1;
    end
`ifdef NEURON_RELU_EN
    act_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
    act_val = sat_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACC;
      S_ACC:   if (beat && last_beat) state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_ACT;
      S_ACT:   state_nxt = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_ACC);
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      bias_r    <= '0;
      act_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          bias_r <= bias;
          acc    <= '0;
          count  <= '0;
        end
        S_ACC: if (beat) begin
          acc   <= acc + prod_ext;
          count <= count + CNT_W'(1);
        end
        S_BIAS: acc <= acc + bias_ext;
        S_ACT: begin
          act_out   <= act_val;
          ovf       <= sat_ovf;
          out_valid <= 1'b1;
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
